// File: rtl/uart_write_if.sv
// rtl/uart_write_if.sv - byte push handshake between a producer and the uart_write FIFO
interface uart_write_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_in;
  logic                 data_valid;
  logic                 data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/uart_write.sv
// rtl/uart_write.sv - FIFO-fed UART transmitter with optional parity and 1/2 stop bits
module uart_write #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_write_if.slave                 in_if,
  output logic                        uart_txd_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 push, pop;
  logic                 fifo_empty, fifo_full;
  logic [DATA_BITS-1:0] head;

  // Transmit state
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q;
  logic                 cnt_wrap;

  assign fifo_full          = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty         = (count_q == '0);
  assign in_if.data_ready   = !reset && !fifo_full;
  assign push               = in_if.data_valid && in_if.data_ready;
  assign head               = mem_q[rd_ptr_q];
  assign cnt_wrap           = (cnt_q == CW'(CLKS_PER_BIT - 1));

  assign uart_txd_out = txd_q;
  assign busy         = (state_q != S_IDLE) || !fifo_empty;
  assign fifo_count   = count_q;

  // FIFO pointer and occupancy next-state; push and pop together leave count unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO data array; contents need no reset because pointers gate every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_if.data_in;
    end
  end

  // Frame sequencer: only a bit-counter wrap advances the state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_wrap) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_wrap) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IW'(DATA_BITS - 1)) begin
            stop_d  = 1'b0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_wrap) begin
          cnt_d   = '0;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_wrap) begin
          cnt_d = '0;
          if ((STOP_BITS == 1) || stop_q) begin
            // Chain straight into the next start bit when data is waiting
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (pop) begin
      shift_d = head;
      par_d   = (^head) ^ (PARITY_ODD != 0);
      cnt_d   = '0;
    end
  end

  // State registers with synchronous reset; reset drops any queued bytes
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      par_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
    end
  end

  // Line driver registered from current state only, so inputs never reach the pin combinationally
  always_ff @(posedge clk) begin
    if (reset) begin
      txd_q <= 1'b1;
    end else begin
      case (state_q)
        S_START:  txd_q <= 1'b0;
        S_DATA:   txd_q <= shift_q[0];
        S_PARITY: txd_q <= par_q;
        default:  txd_q <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_write.sv
// tb/tb_uart_write.sv - directed self-checking bench for uart_write
module tb_uart_write;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid;
  logic [7:0] din;
  logic [1:0] sel;

  always #5 clk = ~clk;

  uart_write_if #(.DATA_BITS(8)) bus0 ();
  uart_write_if #(.DATA_BITS(8)) bus1 ();
  uart_write_if #(.DATA_BITS(8)) bus2 ();
  uart_write_if #(.DATA_BITS(8)) bus3 ();

  assign bus0.data_in = din;
  assign bus1.data_in = din;
  assign bus2.data_in = din;
  assign bus3.data_in = din;
  assign bus0.data_valid = valid && (sel == 2'd0);
  assign bus1.data_valid = valid && (sel == 2'd1);
  assign bus2.data_valid = valid && (sel == 2'd2);
  assign bus3.data_valid = valid && (sel == 2'd3);

  logic       txd [4];
  logic       bsy [4];
  logic       rdy [4];
  logic [2:0] cnt [4];

  assign rdy[0] = bus0.data_ready;
  assign rdy[1] = bus1.data_ready;
  assign rdy[2] = bus2.data_ready;
  assign rdy[3] = bus3.data_ready;

  uart_write dut0 (
    .clk(clk), .reset(reset), .in_if(bus0),
    .uart_txd_out(txd[0]), .busy(bsy[0]), .fifo_count(cnt[0])
  );
  uart_write #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .in_if(bus1),
    .uart_txd_out(txd[1]), .busy(bsy[1]), .fifo_count(cnt[1])
  );
  uart_write #(.PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .reset(reset), .in_if(bus2),
    .uart_txd_out(txd[2]), .busy(bsy[2]), .fifo_count(cnt[2])
  );
  uart_write #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut3 (
    .clk(clk), .reset(reset), .in_if(bus3),
    .uart_txd_out(txd[3]), .busy(bsy[3]), .fifo_count(cnt[3])
  );

  logic       m_txd, m_busy, m_rdy;
  logic [2:0] m_cnt;
  assign m_txd  = txd[sel];
  assign m_busy = bsy[sel];
  assign m_rdy  = rdy[sel];
  assign m_cnt  = cnt[sel];

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_fr  [8];
  logic [7:0]  rx_byte [8];
  logic [7:0]  msg     [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame word: bit0 start, bits1..8 data LSB first, then parity (if any), ones above
  function automatic logic [15:0] frame_bits(input logic [7:0] d);
    logic [15:0] f;
    f      = 16'hFFFF;
    f[0]   = 1'b0;
    f[8:1] = d;
    return f;
  endfunction

  task automatic wait_low(input int limit, output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < limit && m_txd !== 1'b0) begin
      @(negedge clk);
      n++;
    end
    ok = (m_txd === 1'b0);
  endtask

  // Compares every line cycle against exp_fr and samples mid-bit data into rx_byte
  task automatic run_stream(input string tag, input int nframes, input int nbits, input int cpb);
    int bad, flen, f, b, c;
    bad  = 0;
    flen = nbits * cpb;
    for (int k = 0; k < nframes * flen; k++) begin
      f = k / flen;
      b = (k % flen) / cpb;
      c = k % cpb;
      if (m_txd !== exp_fr[f][b]) bad++;
      if (b >= 1 && b <= 8 && c == cpb / 2) rx_byte[f][b-1] = m_txd;
      @(negedge clk);
    end
    check(tag, bad, 0);
  endtask

  task automatic push_one(input logic [7:0] d);
    din   = d;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   bad, viol, push_to;
    logic ok, saw_full;

    msg[0] = 8'h68; msg[1] = 8'h65; msg[2] = 8'h6C; msg[3] = 8'h6C;
    msg[4] = 8'h6F; msg[5] = 8'h21; msg[6] = 8'h21; msg[7] = 8'h21;

    reset = 1'b1; valid = 1'b0; din = 8'h00; sel = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", m_rdy, 0);
    check("rst_txd", m_txd, 1);
    check("rst_busy", m_busy, 0);
    check("rst_count", m_cnt, 0);
    reset = 1'b0;
    #1;
    check("ready_after_release", m_rdy, 1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_txd !== 1'b1 || m_busy !== 1'b0 || m_rdy !== 1'b1 || m_cnt !== 3'd0) bad++;
    end
    check("idle_100", bad, 0);

    // Single 'h' frame, default parameters
    sel = 2'd0;
    push_one(8'h68);
    check("push_count", m_cnt, 1);
    check("push_txd", m_txd, 1);
    @(negedge clk);
    check("pop_count", m_cnt, 0);
    check("pop_busy", m_busy, 1);
    check("pop_txd", m_txd, 1);
    @(negedge clk);
    exp_fr[0] = 16'hFED0;
    run_stream("frame_68", 1, 10, 16);
    check("rx_68", rx_byte[0], 8'h68);
    check("end68_busy", m_busy, 0);
    check("end68_txd", m_txd, 1);

    // Even parity: 0x68 has three ones -> parity 1
    sel = 2'd1;
    push_one(8'h68);
    wait_low(10, ok);
    check("even_start", ok, 1);
    exp_fr[0] = 16'hFED0;
    run_stream("frame_even", 1, 11, 16);
    check("even_end_busy", m_busy, 0);

    // Odd parity -> parity 0
    sel = 2'd2;
    push_one(8'h68);
    wait_low(10, ok);
    check("odd_start", ok, 1);
    exp_fr[0] = 16'hFCD0;
    run_stream("frame_odd", 1, 11, 16);
    check("odd_end_busy", m_busy, 0);

    // "hello!!!" with data_valid held high: contiguous frames and back-pressure
    sel = 2'd0;
    for (int i = 0; i < 8; i++) exp_fr[i] = frame_bits(msg[i]);
    viol = 0; push_to = 0; saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int g;
          g     = 0;
          din   = msg[i];
          valid = 1'b1;
          while (!m_rdy && g < 400) begin
            @(negedge clk);
            g++;
          end
          if (g >= 400) push_to++;
          @(negedge clk);
        end
        valid = 1'b0;
      end
      begin
        logic ok2;
        wait_low(20, ok2);
        check("hello_start", ok2, 1);
        run_stream("hello_stream", 8, 10, 16);
      end
      begin
        for (int i = 0; i < 1300; i++) begin
          if (m_cnt == 3'd4) saw_full = 1'b1;
          if ((m_cnt == 3'd4 && m_rdy) || m_cnt > 3'd4) viol++;
          @(negedge clk);
        end
      end
    join
    check("hello_full_seen", saw_full, 1);
    check("hello_ready_full", viol, 0);
    check("hello_push_timeout", push_to, 0);
    for (int i = 0; i < 8; i++) check($sformatf("hello_rx%0d", i), rx_byte[i], msg[i]);
    check("hello_end_busy", m_busy, 0);

    // Reset during data bit 3 with two bytes queued
    din = 8'h55; valid = 1'b1;
    @(negedge clk);
    din = 8'hA5;
    @(negedge clk);
    din = 8'h3C;
    @(negedge clk);
    valid = 1'b0;
    wait_low(10, ok);
    check("abort_start", ok, 1);
    repeat (4 * 16 + 8) @(negedge clk);
    check("abort_bit3", m_txd, 0);
    check("abort_queued", m_cnt, 2);
    reset = 1'b1;
    @(negedge clk);
    check("abort_txd", m_txd, 1);
    check("abort_count", m_cnt, 0);
    check("abort_busy", m_busy, 0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m_txd !== 1'b1 || m_busy !== 1'b0 || m_cnt !== 3'd0) bad++;
    end
    check("abort_quiet", bad, 0);

    // Two stop bits at 4 clocks/bit: 0x00 then 0xFF back to back
    sel = 2'd3;
    din = 8'h00; valid = 1'b1;
    @(negedge clk);
    din = 8'hFF;
    @(negedge clk);
    valid = 1'b0;
    wait_low(10, ok);
    check("s2_start", ok, 1);
    exp_fr[0] = 16'hFE00;
    exp_fr[1] = 16'hFFFE;
    run_stream("s2_stream", 2, 11, 4);
    check("s2_rx0", rx_byte[0], 8'h00);
    check("s2_rx1", rx_byte[1], 8'hFF);
    check("s2_end_busy", m_busy, 0);
    check("s2_end_txd", m_txd, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_write.md
Name: uart_write

Overview:
UART transmitter that serialises bytes onto a single idle-high line. It is the transmit end of the link that UART_read receives, and it replaces the fixed-pattern serial source used for bring-up. Bytes enter through a valid/ready handshake into a small FIFO. Each byte is sent as a start bit, data bits LSB first, an optional parity bit, then stop bit(s). Bit timing comes from an internal per-bit cycle counter on the single system clock; no derived clocks are used.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit (>=2)
DATA_BITS, 8, data bits per frame (5..8)
PARITY_EN, 0, 1 = append parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, stop bits per frame (1 or 2)
FIFO_DEPTH, 4, input FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
data_in  input  DATA_BITS  byte to transmit
data_valid  input  1  data_in valid this cycle
data_ready  output  1  FIFO can accept; push occurs when data_valid && data_ready
uart_txd_out  output  1  serial line, idle high
busy  output  1  frame in progress or FIFO non-empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently queued

Behaviour:
- Reset (sampled on a clk edge): uart_txd_out=1, busy=0, fifo_count=0, FIFO pointers cleared, FSM=IDLE, bit counter=0. data_ready=0 while reset is high and 1 on the first cycle after release.
- Reset mid-frame aborts the frame. The line is high on the next edge, and the queued data is discarded.
- FIFO: data_ready = (fifo_count != FIFO_DEPTH). A push and a pop in the same cycle leave the count unchanged. Data exits in arrival order. No push is possible when full. The FSM pops only when non-empty.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: txd=1. If FIFO non-empty, pop the head into the shift register, compute parity, clear the bit counter and go to START. Parity is XOR of data bits, inverted when PARITY_ODD.
- START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: txd=shift[0] for CLKS_PER_BIT cycles, then shift right. After DATA_BITS bits go to PARITY if PARITY_EN, else STOP.
- PARITY: txd=parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle, if FIFO non-empty, pop and go directly to START (no extra idle cycles); otherwise go to IDLE.
- Latency: a byte pushed into an empty FIFO while IDLE appears in the FIFO the next cycle. IDLE pops the following cycle. The start bit drives the line on the cycle after the pop, i.e. 3 edges after the push edge.
- Frame length: (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- uart_txd_out is registered, with no combinational path from inputs.
- busy = (FSM != IDLE) || (fifo_count != 0).
- A bit counter wrap at CLKS_PER_BIT-1 is the only state-advance event. A data_valid arriving mid-frame never disturbs timing.

Test Plan:
- Reset release, no input -> txd=1, busy=0, data_ready=1, fifo_count=0 for 100 cycles.
- Default params, push 0x68 ('h') -> txd sequence 0 | 0,0,0,1,0,1,1,0 | 1, each bit exactly 16 cycles, 160 cycles total, then busy=0.
- PARITY_EN=1, push 0x68 -> parity bit 1 with PARITY_ODD=0 and 0 with PARITY_ODD=1. Frame is 176 cycles.
- Push "hello!!!" (8 bytes) back-to-back with data_valid held high -> data_ready drops when fifo_count=4. All 8 frames are contiguous with no idle gap (1280 cycles), and a loopback into UART_read recovers "hello!!!".
- Assert reset during DATA bit 3 of a frame with 2 bytes queued -> txd=1 on the next edge, fifo_count=0, no further frames.
- STOP_BITS=2, CLKS_PER_BIT=4, push 0x00 then 0xFF -> stop high for 8 cycles between frames, and the next start bit follows immediately.
